// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the tiled single-port RAM.
package sp_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Number of d-sized tiles needed to cover n.
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/sp_ram_asic.sv
// Physical single-port macro model: 1-cycle registered read, per-bit write mask.
module sp_ram_asic #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 132
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic [DATA_WIDTH-1:0] bw,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage array has no reset; dout only changes on a read.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[a] <= (mem[a] & ~bw) | (di & bw);
      else    dout   <= mem[a];
    end
  end

endmodule

// File: rtl/sp_ram_tiled.sv
// Logical RAM built from a BANKS x COLS grid of sp_ram_asic macros,
// with a zero-fill sequencer after reset and optional output register.
module sp_ram_tiled
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH       = 10,
  parameter int DATA_WIDTH       = 256,
  parameter int MACRO_ADDR_WIDTH = 8,
  parameter int MACRO_DATA_WIDTH = 132,
  parameter int OUT_REG          = 0,
  parameter int INIT_ON_RESET    = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ,
  input  logic                  RDWEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic [DATA_WIDTH-1:0] BW,
  output logic                  GNT,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  INIT_DONE
);

  localparam int COLS      = ceil_div(DATA_WIDTH, MACRO_DATA_WIDTH);
  localparam int BANK_BITS = ADDR_WIDTH - MACRO_ADDR_WIDTH;
  localparam int BANKS     = 1 << BANK_BITS;
  localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int PAD_W     = COLS * MACRO_DATA_WIDTH;

  state_e                      state, state_nxt;
  logic [MACRO_ADDR_WIDTH-1:0] cnt;
  logic                        done_q;
  logic [BSEL_W-1:0]           bank, bank_q;
  logic                        rd_fire, rd_v1;

  logic [BANKS-1:0]            m_ce;
  logic                        m_we;
  logic [MACRO_ADDR_WIDTH-1:0] m_addr;
  logic [PAD_W-1:0]            m_di, m_bw;
  logic [BANKS-1:0][PAD_W-1:0] bank_dout;
  logic [PAD_W-1:0]            rd_row;
  logic [DATA_WIDTH-1:0]       rd_word;

  assign bank      = BSEL_W'(A >> MACRO_ADDR_WIDTH);
  assign GNT       = REQ & (state == ST_READY);
  assign rd_fire   = GNT & ~RDWEN;
  assign INIT_DONE = done_q;

  // Next state: leave INIT once the last macro row has been cleared.
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && cnt == {MACRO_ADDR_WIDTH{1'b1}}) state_nxt = ST_READY;
  end

  // State, fill row counter and the sticky ready flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == ST_READY);
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  // Macro controls: fill drives every bank at row cnt; users hit one bank.
  // Padding bits of the top column are never written by users.
  always_comb begin
    m_addr                = A[MACRO_ADDR_WIDTH-1:0];
    m_we                  = RDWEN;
    m_di                  = '0;
    m_di[DATA_WIDTH-1:0]  = DI;
    m_bw                  = '0;
    m_bw[DATA_WIDTH-1:0]  = BW;
    m_ce                  = '0;
    if (state == ST_INIT) begin
      m_addr = cnt;
      m_we   = 1'b1;
      m_di   = '0;
      m_bw   = '1;
      m_ce   = '1;
    end else begin
      for (int b = 0; b < BANKS; b++) m_ce[b] = GNT && (bank == BSEL_W'(b));
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sp_ram_asic #(
        .ADDR_WIDTH (MACRO_ADDR_WIDTH),
        .DATA_WIDTH (MACRO_DATA_WIDTH)
      ) u_tile (
        .clk  (CLK),
        .ce   (m_ce[b]),
        .we   (m_we),
        .a    (m_addr),
        .di   (m_di[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH]),
        .bw   (m_bw[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH]),
        .dout (bank_dout[b][c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH])
      );
    end
  end

  // First read stage: track the read and which bank it went to.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_v1  <= 1'b0;
      bank_q <= '0;
    end else begin
      rd_v1 <= rd_fire;
      if (rd_fire) bank_q <= bank;
    end
  end

  assign rd_row  = bank_dout[bank_q];
  assign rd_word = rd_row[DATA_WIDTH-1:0];

  if (PAD_W > DATA_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rd_row[PAD_W-1:DATA_WIDTH];
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  rd_v2;
    logic [DATA_WIDTH-1:0] do_q;
    // Second stage: capture muxed macro data; holds until the next read.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        rd_v2 <= 1'b0;
        do_q  <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) do_q <= rd_word;
      end
    end
    assign RVALID = rd_v2;
    assign DO     = do_q;
  end else begin : g_noreg
    logic rd_seen;
    // Macro dout is unreset; mask DO to zero until a read has completed.
    // bank_q and macro dout only move on reads, so DO holds across writes.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)        rd_seen <= 1'b0;
      else if (rd_fire) rd_seen <= 1'b1;
    end
    assign RVALID = rd_v1;
    assign DO     = rd_seen ? rd_word : '0;
  end

endmodule

// File: tb/tb_sp_ram_tiled.sv
// Directed bench: three instances (defaults, OUT_REG=1, 200-bit word) share stimulus.
module tb_sp_ram_tiled;

  logic         clk = 1'b0;
  logic         rstn, req, rdwen;
  logic [9:0]   a;
  logic [255:0] di, bw;

  logic         gnt0, rv0, idn0, gnt1, rv1, idn1, gnt2, rv2, idn2;
  logic [255:0] do0, do1;
  logic [199:0] do2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sp_ram_tiled u_dut0 (
    .CLK(clk), .RSTN(rstn), .REQ(req), .RDWEN(rdwen), .A(a), .DI(di), .BW(bw),
    .GNT(gnt0), .RVALID(rv0), .DO(do0), .INIT_DONE(idn0));

  sp_ram_tiled #(.OUT_REG(1)) u_dut1 (
    .CLK(clk), .RSTN(rstn), .REQ(req), .RDWEN(rdwen), .A(a), .DI(di), .BW(bw),
    .GNT(gnt1), .RVALID(rv1), .DO(do1), .INIT_DONE(idn1));

  sp_ram_tiled #(.DATA_WIDTH(200)) u_dut2 (
    .CLK(clk), .RSTN(rstn), .REQ(req), .RDWEN(rdwen), .A(a), .DI(di[199:0]), .BW(bw[199:0]),
    .GNT(gnt2), .RVALID(rv2), .DO(do2), .INIT_DONE(idn2));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct {
    logic         w;
    logic [9:0]   a;
    logic [255:0] di;
    logic [255:0] bw;
    logic [255:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] ones, pat, pat_m, exp_row;
    logic         gnt_seen, rv_seen;
    int           cyc;

    ones  = '1;
    pat   = {4{64'h0123456789ABCDEF}};
    pat_m = {{3{64'h0123456789ABCDEF}}, 64'h012345670000CDEF};
    tv[0]  = '{1'b0, 10'h000, '0,   '0,                          '0};
    tv[1]  = '{1'b0, 10'h0FF, '0,   '0,                          '0};
    tv[2]  = '{1'b0, 10'h3FF, '0,   '0,                          '0};
    tv[3]  = '{1'b1, 10'h005, ones, 256'hFF,                     '0};
    tv[4]  = '{1'b0, 10'h005, '0,   '0,                          256'hFF};
    tv[5]  = '{1'b1, 10'h0FF, 256'hAA, ones,                     '0};
    tv[6]  = '{1'b1, 10'h100, 256'h55, ones,                     '0};
    tv[7]  = '{1'b1, 10'h007, ones, ones,                        '0};
    tv[8]  = '{1'b0, 10'h007, '0,   '0,                          ones};
    tv[9]  = '{1'b1, 10'h007, '0,   {128'h0, {128{1'b1}}},       '0};
    tv[10] = '{1'b0, 10'h007, '0,   '0,                          {{128{1'b1}}, 128'h0}};
    tv[11] = '{1'b1, 10'h3FF, pat,  ones,                        '0};
    tv[12] = '{1'b0, 10'h3FF, '0,   '0,                          pat};
    tv[13] = '{1'b1, 10'h3FF, '0,   256'hFFFF0000,               '0};
    tv[14] = '{1'b0, 10'h3FF, '0,   '0,                          pat_m};

    // Reset state, with a write request held high throughout the fill.
    rstn = 1'b0; req = 1'b1; rdwen = 1'b1; a = 10'h000; di = ones; bw = ones;
    repeat (2) @(negedge clk);
    chk("rst_rvalid", {rv2, rv1, rv0}, 3'b000);
    chk("rst_gnt", {gnt2, gnt1, gnt0}, 3'b000);
    chk("rst_init_done", {idn2, idn1, idn0}, 3'b000);
    chk("rst_do0", do0, '0);
    chk("rst_do1", do1, '0);
    chk("rst_do2", {56'h0, do2}, '0);

    // Fill up to row 100, then reset again mid-fill.
    gnt_seen = 1'b0; rv_seen = 1'b0;
    rstn = 1'b1;
    repeat (100) begin
      @(negedge clk);
      gnt_seen |= gnt0 | gnt1 | gnt2;
      rv_seen  |= rv0 | rv1 | rv2;
    end
    chk("mid_init_done", {idn2, idn1, idn0}, 3'b000);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_init_done", {idn2, idn1, idn0}, 3'b000);
    rstn = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (idn0) break;
      gnt_seen |= gnt0 | gnt1 | gnt2;
      rv_seen  |= rv0 | rv1 | rv2;
    end
    req = 1'b0;
    chk("fill_cycles", 256'(cyc), 256'd256);
    chk("fill_done_all", {idn2, idn1, idn0}, 3'b111);
    chk("fill_no_gnt", 256'(gnt_seen), '0);
    chk("fill_no_rvalid", 256'(rv_seen), '0);

    // Table: single transactions separated by idle cycles.
    for (int i = 0; i < NV; i++) begin
      req = 1'b1; rdwen = tv[i].w; a = tv[i].a; di = tv[i].di; bw = tv[i].bw;
      #1;
      chk($sformatf("v%0d_gnt", i), {gnt2, gnt1, gnt0}, 3'b111);
      @(negedge clk);
      req = 1'b0;
      if (tv[i].w) begin
        chk($sformatf("v%0d_wr_rvalid", i), {rv2, rv1, rv0}, 3'b000);
        @(negedge clk);
        chk($sformatf("v%0d_wr_rvalid2", i), {rv2, rv1, rv0}, 3'b000);
      end else begin
        exp_row = tv[i].exp;
        chk($sformatf("v%0d_rvalid_c1", i), {rv2, rv1, rv0}, 3'b101);
        chk($sformatf("v%0d_do0", i), do0, exp_row);
        chk($sformatf("v%0d_do2", i), {56'h0, do2}, {56'h0, exp_row[199:0]});
        @(negedge clk);
        chk($sformatf("v%0d_rvalid_c2", i), {rv2, rv1, rv0}, 3'b010);
        chk($sformatf("v%0d_do1", i), do1, exp_row);
        chk($sformatf("v%0d_do0_hold", i), do0, exp_row);
      end
    end

    // Back-to-back reads across the bank boundary.
    req = 1'b1; rdwen = 1'b0; a = 10'h0FF;
    @(negedge clk);
    a = 10'h100;
    chk("b2b_c1_rv", {rv2, rv1, rv0}, 3'b101);
    chk("b2b_c1_do0", do0, 256'hAA);
    chk("b2b_c1_do2", {56'h0, do2}, 256'hAA);
    @(negedge clk);
    req = 1'b0;
    chk("b2b_c2_rv", {rv2, rv1, rv0}, 3'b111);
    chk("b2b_c2_do0", do0, 256'h55);
    chk("b2b_c2_do1", do1, 256'hAA);
    chk("b2b_c2_do2", {56'h0, do2}, 256'h55);
    @(negedge clk);
    chk("b2b_c3_rv", {rv2, rv1, rv0}, 3'b010);
    chk("b2b_c3_do1", do1, 256'h55);
    chk("b2b_c3_do0", do0, 256'h55);

    // DO holds across a write to the same address.
    req = 1'b1; rdwen = 1'b1; a = 10'h100; di = 256'h77; bw = ones;
    @(negedge clk);
    req = 1'b0;
    chk("hold_rv", {rv2, rv1, rv0}, 3'b000);
    chk("hold_do0", do0, 256'h55);
    chk("hold_do1", do1, 256'h55);
    chk("hold_do2", {56'h0, do2}, 256'h55);
    @(negedge clk);
    chk("hold_do1_c2", do1, 256'h55);

    // Read granted, then reset while it is in flight.
    req = 1'b1; rdwen = 1'b0; a = 10'h3FF;
    @(posedge clk);
    #2;
    rstn = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("drop_rst_rv", {rv2, rv1, rv0}, 3'b000);
    chk("drop_rst_do1", do1, '0);
    rstn = 1'b1;
    rv_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      rv_seen |= rv0 | rv1 | rv2;
    end
    chk("drop_no_rvalid", 256'(rv_seen), '0);
    chk("drop_do0", do0, '0);
    chk("drop_do1", do1, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
